// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on both sides.
// Define KS_ADDSUB_EN to honour the sub port; otherwise sub is ignored (add only).
module ks_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);

  logic sub_eff;
`ifdef KS_ADDSUB_EN
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
`endif

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] g_in_fold;
  logic [WIDTH-1:0] p_in_fold;
  logic             c0;

  assign bx   = b ^ {WIDTH{sub_eff}};
  assign c0   = cin ^ sub_eff;
  assign p_in = a ^ bx;
  assign g_in = a & bx;

  // c0 is merged into bit 0 as a bit -1 generate; bit 0's group propagate becomes 0
  // so every prefix reaching bit 0 is a pure generate over [i:-1].
  assign g_in_fold = {g_in[WIDTH-1:1], g_in[0] | (p_in[0] & c0)};
  assign p_in_fold = {p_in[WIDTH-1:1], 1'b0};

  // Index 0 is the P/G stage, index k+1 holds the result of prefix level k.
  logic [LEVELS:0]            valid_reg;
  logic [LEVELS:0][WIDTH-1:0] g_reg;
  logic [LEVELS:0][WIDTH-1:0] p_reg;
  logic [LEVELS:0][WIDTH-1:0] pbit_reg;
  logic [LEVELS:0]            c0_reg;
  logic [LEVELS:0]            a_msb_reg;
  logic [LEVELS:0]            bx_msb_reg;

  logic [LEVELS-1:0][WIDTH-1:0] g_next;
  logic [LEVELS-1:0][WIDTH-1:0] p_next;

  genvar gk, gi;
  generate
    for (gk = 0; gk < LEVELS; gk++) begin : g_level
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi >= (1 << gk)) begin : g_combine
          assign g_next[gk][gi] = g_reg[gk][gi] | (p_reg[gk][gi] & g_reg[gk][gi - (1 << gk)]);
          assign p_next[gk][gi] = p_reg[gk][gi] & p_reg[gk][gi - (1 << gk)];
        end else begin : g_pass
          assign g_next[gk][gi] = g_reg[gk][gi];
          assign p_next[gk][gi] = p_reg[gk][gi];
        end
      end
    end
  endgenerate

  // The group propagate after the last level is never needed.
  logic [WIDTH-1:0] unused_p_top;
  assign unused_p_top = p_reg[LEVELS];

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;

  assign carry     = {g_reg[LEVELS][WIDTH-2:0], c0_reg[LEVELS]};
  assign sum_next  = pbit_reg[LEVELS] ^ carry;
  assign cout_next = g_reg[LEVELS][WIDTH-1];
  assign ovf_next  = (a_msb_reg[LEVELS] == bx_msb_reg[LEVELS]) &&
                     (sum_next[WIDTH-1] != a_msb_reg[LEVELS]);

  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             adv;

  assign adv       = ~out_valid_reg | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg     <= '0;
      g_reg         <= '0;
      p_reg         <= '0;
      pbit_reg      <= '0;
      c0_reg        <= '0;
      a_msb_reg     <= '0;
      bx_msb_reg    <= '0;
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (adv) begin
      valid_reg[0]  <= in_valid;
      g_reg[0]      <= g_in_fold;
      p_reg[0]      <= p_in_fold;
      pbit_reg[0]   <= p_in;
      c0_reg[0]     <= c0;
      a_msb_reg[0]  <= a[WIDTH-1];
      bx_msb_reg[0] <= bx[WIDTH-1];
      for (int k = 0; k < LEVELS; k++) begin
        valid_reg[k+1]  <= valid_reg[k];
        g_reg[k+1]      <= g_next[k];
        p_reg[k+1]      <= p_next[k];
        pbit_reg[k+1]   <= pbit_reg[k];
        c0_reg[k+1]     <= c0_reg[k];
        a_msb_reg[k+1]  <= a_msb_reg[k];
        bx_msb_reg[k+1] <= bx_msb_reg[k];
      end
      out_valid_reg <= valid_reg[LEVELS];
      // Result registers only change when a real result lands, so bubbles leave them alone.
      if (valid_reg[LEVELS]) begin
        sum_reg  <= sum_next;
        cout_reg <= cout_next;
        ovf_reg  <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Self-checking bench for ks_adder_pipe (WIDTH=16): vector table, stall, reset and
// back-to-back streams, all results checked in order through a scoreboard queue.
module tb_ks_adder_pipe;

  localparam int W = 16;
  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  ks_adder_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   txn = 0;
  int   last_out_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vc, input logic vs);
    exp_t        e;
    logic [15:0] bxm;
    logic        c0m;
    logic [16:0] r;
`ifdef KS_ADDSUB_EN
    bxm = vs ? ~vb : vb;
    c0m = vc ^ vs;
`else
    bxm = vb;
    c0m = vc;
    if (vs) bxm = vb;
`endif
    r    = {1'b0, va} + {1'b0, bxm} + {16'd0, c0m};
    e.s  = r[15:0];
    e.co = r[16];
    e.ov = (va[15] == bxm[15]) && (r[15] != va[15]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                      input logic vs, input exp_t e, output int acc);
    int   n;
    logic ok;
    n = 0;
    acc = -1;
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      ok  = in_ready;
      acc = cyc;
      @(posedge clk);
      #1;
      if (ok) begin
        q.push_back(e);
        break;
      end
      n++;
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rand(output int acc);
    logic [15:0] va, vb;
    logic        vc, vs;
    va = 16'($urandom);
    vb = 16'($urandom);
    vc = 1'($urandom);
    vs = 1'($urandom);
    send(va, vb, vc, vs, model(va, vb, vc, vs), acc);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results still outstanding, required 0", q.size());
    end
  endtask

  // Scoreboard: every transfer (out_valid && out_ready) pops the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, required no result", sum, cout, ovf);
      end else begin
        e = q.pop_front();
        if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
          errors++;
          $display("FAIL result txn %0d: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                   txn, sum, cout, ovf, e.s, e.co, e.ov);
        end else begin
          $display("txn %0d sum=%h cout=%b ovf=%b ok", txn, sum, cout, ovf);
        end
      end
      txn++;
      last_out_cyc = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl [10];
  int   acc;
  int   first_acc;
  int   cnt;
  int   n;

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
`ifdef KS_ADDSUB_EN
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[8] = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[9] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`else
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
    tbl[8] = '{16'h0007, 16'h0007, 1'b0, 1'b1, 16'h000E, 1'b0, 1'b0};
    tbl[9] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0};
`endif
    tbl[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[7] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_sum", {16'd0, sum}, 0);
    chk("reset_cout", {31'd0, cout}, 0);
    chk("reset_ovf", {31'd0, ovf}, 0);
    chk("reset_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;

    // Latency of a single operation through an empty pipeline.
    send(tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].sub, '{tbl[0].s, tbl[0].co, tbl[0].ov}, acc);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("latency", cyc - acc, LAT);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, '{tbl[i].s, tbl[i].co, tbl[i].ov}, acc);
    wait_drain();

    // Stall: out_ready low for relative cycles 8..15 while 10 operations stream in.
    fork
      begin
        int sacc;
        for (int i = 0; i < 10; i++) send_rand(sacc);
      end
      begin
        logic [15:0] hs;
        logic        hc, ho, held;
        held = 0; hs = '0; hc = 0; ho = 0;
        for (int c = 0; c < 30; c++) begin
          out_ready = (c >= 8 && c <= 15) ? 1'b0 : 1'b1;
          @(negedge clk);
          if (out_valid && !out_ready) begin
            chk("stall_in_ready", {31'd0, in_ready}, 0);
            if (held) begin
              chk("stall_sum_held", {16'd0, sum}, {16'd0, hs});
              chk("stall_flags_held", {30'd0, cout, ovf}, {30'd0, hc, ho});
            end
            held = 1; hs = sum; hc = cout; ho = ovf;
          end else begin
            held = 0;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Reset with four operations in flight; none of them may surface afterwards.
    for (int i = 0; i < 4; i++) send_rand(acc);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_sum", {16'd0, sum}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready_stalled", {31'd0, in_ready}, 1);
    q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    send(tbl[3].a, tbl[3].b, tbl[3].cin, tbl[3].sub, '{tbl[3].s, tbl[3].co, tbl[3].ov}, acc);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) cnt++;
      @(posedge clk);
      #1;
    end
    chk("post_reset_result_count", cnt, 1);
    chk("post_reset_queue_empty", q.size(), 0);

    // Back-to-back stream: one accept per cycle in, one result per cycle out.
    send_rand(first_acc);
    for (int i = 1; i < 1000; i++) send_rand(acc);
    wait_drain();
    chk("b2b_span", last_out_cyc - first_acc, 999 + LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_adder_pipe.md
KS_ADDER_PIPE -- requirements
Module: ks_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are powers of two from 4 to 64.
REQ-002 SHALL have localparam LEVELS = log2(WIDTH), the number of Kogge-Stone prefix levels.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in; acts as borrow-in in subtract mode.
REQ-009 SHALL have port sub, input, 1 bit: 1 selects subtraction (only with KS_ADDSUB_EN).
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: the result.
REQ-013 SHALL have port cout, output, 1 bit: carry-out from the MSB.
REQ-014 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 SHALL compute the effective operands as bx = sub ? ~b : b and c0 = cin ^ sub.
REQ-016 SHALL compute {cout, sum} = a + bx + c0, using WIDTH-bit arithmetic with the carry kept in cout.
REQ-017 SHALL assert ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]).
REQ-018 SHALL form bitwise P = a ^ bx and G = a & bx, then combine (G,P) pairs at span 2^k in prefix level k = 0..LEVELS-1.
REQ-019 SHALL fold c0 in as a bit -1 generate term, so that carry[i] is the group generate over [i-1:-1].
REQ-020 SHALL make sum = P ^ carry and cout = group generate over [WIDTH-1:-1].
REQ-021 SHALL register the pipeline as follows.
  - Stage 0: the P/G registers.
  - One register per prefix level.
  - A final sum/flag register.
REQ-022 SHALL therefore have a latency of LEVELS+2 cycles from acceptance to out_valid, with no other combinational path between the in and out handshakes.
REQ-023 SHALL carry a valid bit in every stage; a stage holding no valid data is a bubble.
REQ-024 SHALL advance the whole pipeline only when adv = ~out_valid | out_ready.
REQ-025 SHALL drive in_ready = adv.
REQ-026 SHALL treat an input as accepted only when in_valid && in_ready.
REQ-027 SHALL load a bubble into stage 0 when adv=1 and in_valid=0.
REQ-028 SHALL hold every stage, including sum, cout and ovf, stable while adv=0.
REQ-029 SHALL sustain one result per cycle when out_ready is held high.
REQ-030 SHALL keep sum, cout and ovf unchanged while out_valid=0; the previous values are don't-care to the consumer.
REQ-031 SHALL keep results in acceptance order, with no loss or duplication, under any pattern of in_valid and out_ready.

Reset
REQ-032 SHALL clear all stage valid bits to 0 on rst=1, immediately and asynchronously.
REQ-033 SHALL clear sum, cout and ovf to 0 on rst=1.
REQ-034 SHALL discard any in-flight operands on rst=1, including in the middle of a stall.
REQ-035 SHALL, while rst=1, drive in_ready=1 (because out_valid=0).
REQ-036 SHALL accept inputs on the first rising clk edge after rst deasserts.

Configuration
REQ-037 SHALL use the macro KS_ADDSUB_EN.
REQ-038 SHALL, when KS_ADDSUB_EN is defined, implement the sub port as specified in REQ-015.
REQ-039 SHALL, when KS_ADDSUB_EN is undefined, ignore sub internally as constant 0, so that bx = b and c0 = cin; the port remains present.

Verification
REQ-040 SHALL cover each scenario below on a bench with WIDTH=16, where the latency is 6 cycles.
  - a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, with out_valid exactly 6 cycles after acceptance.
  - a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
  - a=0x0005, b=0x0007, cin=0, sub=1 (KS_ADDSUB_EN defined) -> sum=0xFFFE, cout=0, ovf=0.
  - The same stimulus with KS_ADDSUB_EN undefined -> sum=0x000C, cout=0.
  - Stall test: stream 10 random operand sets, out_ready=0 from cycle 8 to 15 -> in_ready=0 while out_valid && !out_ready; sum and flags held; all 10 results later match the model, in order.
  - Reset test: assert rst with 4 operand sets in flight -> out_valid=0 and sum=0 immediately; in_ready=1; none of the 4 results ever appears.
  - Also run a back-to-back 1000-operation random stream with out_ready=1 -> one result per cycle, each equal to the a+bx+c0 reference model.
